input_conditioner: RTL

- Front end that produces the control inputs consumed by the central pet FSM.
- Takes raw asynchronous board buttons and the tilt switch, then synchronises and debounces them.
- Emits clean one-cycle command pulses and a debounced tilt level.
- Also encodes the test-mode gesture into the botonTest/pulseTest pair: long-press test, count play presses, emit.

---
 rtl/input_conditioner_pkg.sv | 32 +++
 rtl/input_conditioner_debounce_filter.sv | 47 ++++
 rtl/input_conditioner.sv | 127 ++++++++++++
 3 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the button/tilt front end: input indices, test FSM
// state encoding, test command width and parameter defaults.
package input_conditioner_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF    = 20;
  localparam int unsigned LONG_PRESS_CYCLES_DEF  = 50;
  localparam int unsigned TEST_WINDOW_CYCLES_DEF = 100;

  localparam int unsigned PULSE_W = 4;
  localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(15);

  localparam int unsigned N_INPUTS  = 6;
  localparam int unsigned IDX_SLEEP = 0;
  localparam int unsigned IDX_AWAKE = 1;
  localparam int unsigned IDX_FEED  = 2;
  localparam int unsigned IDX_PLAY  = 3;
  localparam int unsigned IDX_GIRO  = 4;
  localparam int unsigned IDX_TEST  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_EMIT    = 2'd3
  } test_state_t;

  // Saturating increment of the play-press count.
  function automatic logic [PULSE_W-1:0] sat_inc(input logic [PULSE_W-1:0] v);
    return (v == PULSE_MAX) ? v : v + PULSE_W'(1);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_filter.sv
// 2-FF synchroniser followed by a stability counter; rise is registered and
// coincides with the debounced level going high.
module debounce_filter
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Level follows only after DEBOUNCE_CYCLES consecutive mismatching cycles.
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          rise  <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Button/tilt front end for the pet FSM: debounced command pulses, tilt level,
// and the long-press test gesture encoded as botonTest/pulseTest.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_PRESS_CYCLES  = LONG_PRESS_CYCLES_DEF,
  parameter int unsigned TEST_WINDOW_CYCLES = TEST_WINDOW_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               raw_sleep,
  input  logic               raw_awake,
  input  logic               raw_feed,
  input  logic               raw_play,
  input  logic               raw_giro,
  input  logic               raw_test,
  output logic               botonSleep,
  output logic               botonAwake,
  output logic               botonFeed,
  output logic               botonPlay,
  output logic               giro,
  output logic               botonTest,
  output logic [PULSE_W-1:0] pulseTest
);

  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int unsigned WIN_W  = $clog2(TEST_WINDOW_CYCLES + 1);

  logic [N_INPUTS-1:0] raw_vec;
  logic [N_INPUTS-1:0] lvl;
  logic [N_INPUTS-1:0] rise;
  logic                unused_bits;

  test_state_t         state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic [PULSE_W-1:0]  count;

  assign raw_vec = {raw_test, raw_giro, raw_play, raw_feed, raw_awake, raw_sleep};

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_filt
    debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_vec[i]),
      .level(lvl[i]),
      .rise (rise[i])
    );
  end

  assign giro        = lvl[IDX_GIRO];
  assign unused_bits = ^{lvl[IDX_SLEEP], lvl[IDX_AWAKE], lvl[IDX_FEED], rise[IDX_GIRO]};

  // Command pulses; play is swallowed while a test gesture owns the button.
  always_ff @(posedge clk) begin
    if (rst) begin
      botonSleep <= 1'b0;
      botonAwake <= 1'b0;
      botonFeed  <= 1'b0;
      botonPlay  <= 1'b0;
    end else begin
      botonSleep <= rise[IDX_SLEEP];
      botonAwake <= rise[IDX_AWAKE];
      botonFeed  <= rise[IDX_FEED];
      botonPlay  <= rise[IDX_PLAY] && !(state == ST_HOLD || state == ST_COLLECT);
    end
  end

  // Test gesture FSM. The collection window only advances while both play and
  // test are released, so the test release and a press in progress never
  // count as idle time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      win_cnt   <= '0;
      count     <= '0;
      botonTest <= 1'b0;
      pulseTest <= '0;
    end else begin
      botonTest <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise[IDX_TEST]) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (!lvl[IDX_TEST]) begin
            state <= ST_IDLE;
          end else if (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
            state   <= ST_COLLECT;
            count   <= '0;
            win_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_COLLECT: begin
          if (rise[IDX_TEST]) begin
            state <= ST_IDLE;
          end else if (rise[IDX_PLAY]) begin
            count   <= sat_inc(count);
            win_cnt <= '0;
          end else if (!lvl[IDX_PLAY] && !lvl[IDX_TEST]) begin
            if (win_cnt == WIN_W'(TEST_WINDOW_CYCLES - 1)) begin
              state <= (count != '0) ? ST_EMIT : ST_IDLE;
            end else begin
              win_cnt <= win_cnt + WIN_W'(1);
            end
          end
        end
        ST_EMIT: begin
          botonTest <= 1'b1;
          pulseTest <= count;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
